// File: rtl/sfifo_ft_w128_d512.sv
// Single-clock first-word-fall-through FIFO with RAM storage and registered flags.
// dout is a register loaded from RAM (or bypassed from din) so the head word is valid without rd_en.
module sfifo_ft_w128_d512 #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  data_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic              do_wr;
    logic              do_rd;
    logic              load_mem;
    logic              load_din;
    logic [CNT_W-1:0]  count_d;

    assign do_wr      = wr_en & ~full;
    assign do_rd      = rd_en & ~empty;
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    // With two or more words stored, the next head is already in RAM and never the write target.
    assign load_mem = do_rd && (data_count > CNT_W'(1));
    assign load_din = do_wr && (empty || (do_rd && (data_count == CNT_W'(1))));

    always_comb begin
        count_d = data_count;
        case ({do_wr, do_rd})
            2'b10:   count_d = data_count + CNT_W'(1);
            2'b01:   count_d = data_count - CNT_W'(1);
            default: count_d = data_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout       <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (load_mem) begin
                dout <= mem[rd_ptr_nxt];
            end else if (load_din) begin
                dout <= din;
            end
            data_count <= count_d;
            full       <= (count_d == CNT_W'(DEPTH));
            empty      <= (count_d == '0);
        end
    end

endmodule

// File: tb/tb_sfifo_ft_w128_d512.sv
// Bench for sfifo_ft_w128_d512: directed corner cases plus randomized traffic against a queue model.
module tb_sfifo_ft_w128_d512;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned CNT_W  = 10;

    logic              clk;
    logic              rstn;
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  data_count;

    int n_cmp;
    int n_err;

    logic [DATA_W-1:0] q [$];
    logic [DATA_W-1:0] last_pop;

    sfifo_ft_w128_d512 #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .data_count(data_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_model();
        logic [DATA_W-1:0] exp_dout;
        exp_dout = (q.size() > 0) ? q[0] : last_pop;
        check("dout", dout, exp_dout);
        check("empty", DATA_W'(empty), DATA_W'(q.size() == 0));
        check("full", DATA_W'(full), DATA_W'(q.size() == DEPTH));
        check("data_count", DATA_W'(data_count), DATA_W'(q.size()));
    endtask

    // One clock: drive, let the edge happen, advance the queue model, then compare.
    task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
        bit push_ok;
        bit pop_ok;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        push_ok = w && (q.size() < DEPTH);
        pop_ok  = r && (q.size() > 0);
        if (pop_ok) last_pop = q.pop_front();
        if (push_ok) q.push_back(d);
        #1;
        check_model();
    endtask

    initial begin
        logic [DATA_W-1:0] a5;
        logic [DATA_W-1:0] x;
        n_cmp    = 0;
        n_err    = 0;
        last_pop = '0;
        rstn     = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        a5       = {16{8'hA5}};

        // Reset state
        #12;
        check("rst_empty", DATA_W'(empty), DATA_W'(1));
        check("rst_full", DATA_W'(full), DATA_W'(0));
        check("rst_count", DATA_W'(data_count), DATA_W'(0));
        check("rst_dout", dout, '0);
        rstn = 1'b1;

        // Single write, FWFT visibility, single pop
        step(1'b1, 1'b0, a5);
        check("a5_empty", DATA_W'(empty), DATA_W'(0));
        check("a5_dout", dout, a5);
        check("a5_count", DATA_W'(data_count), DATA_W'(1));
        step(1'b0, 1'b0, '0);
        check("a5_hold", dout, a5);
        step(1'b0, 1'b1, '0);
        check("a5_pop_empty", DATA_W'(empty), DATA_W'(1));
        check("a5_pop_count", DATA_W'(data_count), DATA_W'(0));
        step(1'b0, 1'b1, '0);
        check("empty_read_dout", dout, a5);

        // Fill to full, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i));
        check("fill_full", DATA_W'(full), DATA_W'(1));
        check("fill_count", DATA_W'(data_count), DATA_W'(DEPTH));
        step(1'b1, 1'b0, {DATA_W{1'b1}});
        check("ovf_count", DATA_W'(data_count), DATA_W'(DEPTH));
        step(1'b1, 1'b1, {DATA_W{1'b1}});
        check("ovf_pop_count", DATA_W'(data_count), DATA_W'(DEPTH - 1));
        check("ovf_pop_head", dout, DATA_W'(1));
        step(1'b1, 1'b0, DATA_W'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_order", dout, DATA_W'(i));
            step(1'b0, 1'b1, '0);
        end
        check("drain_empty", DATA_W'(empty), DATA_W'(1));

        // Simultaneous write and pop at data_count=1
        step(1'b1, 1'b0, rand_word());
        x = rand_word();
        step(1'b1, 1'b1, x);
        check("wr_rd_cnt1_count", DATA_W'(data_count), DATA_W'(1));
        check("wr_rd_cnt1_dout", dout, x);
        step(1'b0, 1'b1, '0);

        // Randomized traffic with phases biased toward filling, steady state and draining
        for (int i = 0; i < 2000; i++) begin
            int pw;
            int pr;
            if (i < 700) begin
                pw = 90;
                pr = 30;
            end else if (i < 1400) begin
                pw = 80;
                pr = 45;
            end else begin
                pw = 20;
                pr = 90;
            end
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, rand_word());
        end

        // Asynchronous reset with 300 words stored
        while (q.size() > 0) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, rand_word());
        check("pre_rst_count", DATA_W'(data_count), DATA_W'(300));
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_empty", DATA_W'(empty), DATA_W'(1));
        check("midrst_count", DATA_W'(data_count), DATA_W'(0));
        check("midrst_full", DATA_W'(full), DATA_W'(0));
        check("midrst_dout", dout, '0);
        q.delete();
        last_pop = '0;
        #2;
        rstn = 1'b1;
        x = rand_word();
        step(1'b1, 1'b0, x);
        check("post_rst_dout", dout, x);
        step(1'b1, 1'b0, rand_word());
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        check("post_rst_empty", DATA_W'(empty), DATA_W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
